ov7670_frame_writer: RTL and testbench

//   Downstream consumer of the OV7670 controller's pixel stream (newPixel/pixelData).

---
 rtl/ov7670_frame_writer_if.sv | 12 +
 rtl/ov7670_frame_writer.sv | 137 +++++++++++++
 tb/tb_ov7670_frame_writer.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ov7670_frame_writer_if.sv
// Frame-buffer write port: registered request with address/data, acknowledged by memory.
interface ov7670_frame_writer_if #(
    parameter int ADDR_W = 17
);
    logic              memReq;
    logic [ADDR_W-1:0] memAddr;
    logic [15:0]       memData;
    logic              memAck;

    modport master (output memReq, memAddr, memData, input memAck);
    modport slave  (input memReq, memAddr, memData, output memAck);
endinterface

// File: rtl/ov7670_frame_writer.sv
// OV7670 frame writer: frames the pixel stream on vsync, tags each pixel with a linear
// frame-buffer address, buffers {addr,data} in a small FIFO and drains it over req/ack.
//
// state  | meaning
// IDLE   | no frame seen since reset; pixels ignored
// ACTIVE | capturing pixels of the current frame
// DONE   | last pixel of the frame captured; pixels ignored until next vsync
module ov7670_frame_writer #(
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 240,
    parameter int ADDR_W     = 17,
    parameter int BASE_ADDR  = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         vsync,
    input  logic                         newPixel,
    input  logic [15:0]                  pixelData,
    ov7670_frame_writer_if.master        mem,
    output logic                         overflow,
    output logic                         frameDone,
    output logic [7:0]                   frameCount,
    output logic                         busy
);
    localparam int                PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(WIDTH * HEIGHT - 1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    state_t            state;
    logic              vs_s1, vs_s2, vs_d, pix_d1;
    logic              frame_start, pix_edge, capture, push, pop;
    logic [ADDR_W-1:0] pix_idx;
    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [15:0]       fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_next;
    logic [PTR_W:0]    count;

    assign frame_start = vs_s2 & ~vs_d;
    assign pix_edge    = newPixel & ~pix_d1;
    // frameStart has priority: a pixel arriving with it is discarded
    assign capture     = (state == ACTIVE) & pix_edge & ~frame_start;
    assign pop         = mem.memReq & mem.memAck;
    // a completing write frees its slot in the same cycle, so a full FIFO still accepts
    assign push        = capture & ((count != (PTR_W+1)'(FIFO_DEPTH)) | pop);
    assign rd_next     = rd_ptr + PTR_W'(1);
    assign busy        = (count != '0) | mem.memReq;

    // vsync synchronizer plus edge flops for vsync and newPixel
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vs_s1  <= 1'b0;
            vs_s2  <= 1'b0;
            vs_d   <= 1'b0;
            pix_d1 <= 1'b0;
        end else begin
            vs_s1  <= vsync;
            vs_s2  <= vs_s1;
            vs_d   <= vs_s2;
            pix_d1 <= newPixel;
        end
    end

    // frame FSM: pixel index, frame completion pulse and frame counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            pix_idx    <= '0;
            frameDone  <= 1'b0;
            frameCount <= 8'd0;
        end else begin
            frameDone <= 1'b0;
            if (frame_start) begin
                state      <= ACTIVE;
                pix_idx    <= '0;
                frameCount <= frameCount + 8'd1;
            end else if (capture) begin
                pix_idx <= pix_idx + ADDR_W'(1);
                if (pix_idx == LAST_IDX) begin
                    state     <= DONE;
                    frameDone <= 1'b1;
                end
            end
        end
    end

    // FIFO storage; entries are only read once written, so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= BASE + pix_idx;
            fifo_data[wr_ptr] <= pixelData;
        end
    end

    // FIFO pointers, occupancy and sticky overflow; the head stays until its write completes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_next;
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
            if (capture && !push) overflow <= 1'b1;
        end
    end

    // memory port: present the FIFO head, advance to the next entry on completion
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem.memReq  <= 1'b0;
            mem.memAddr <= '0;
            mem.memData <= 16'd0;
        end else if (!mem.memReq) begin
            if (count != '0) begin
                mem.memReq  <= 1'b1;
                mem.memAddr <= fifo_addr[rd_ptr];
                mem.memData <= fifo_data[rd_ptr];
            end
        end else if (mem.memAck) begin
            if (count > (PTR_W+1)'(1)) begin
                mem.memAddr <= fifo_addr[rd_next];
                mem.memData <= fifo_data[rd_next];
            end else begin
                mem.memReq <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ov7670_frame_writer.sv
// Directed bench for ov7670_frame_writer with a 4x2 frame and a 4-entry FIFO.
module tb_ov7670_frame_writer;
    localparam int AW = 17;

    typedef struct {
        logic [15:0] data;
        logic        w;
        logic [16:0] addr;
        logic        done;
    } vec_t;

    typedef struct {
        logic [16:0] a;
        logic [15:0] d;
    } wr_t;

    logic        clk;
    logic        reset;
    logic        vsync;
    logic        newPixel;
    logic [15:0] pixelData;
    logic        overflow;
    logic        frameDone;
    logic [7:0]  frameCount;
    logic        busy;

    int n_err;
    int n_checks;
    int req_cycles;
    int fd_cycles;
    wr_t wq[$];
    vec_t t2 [3];
    vec_t t4 [9];

    ov7670_frame_writer_if #(.ADDR_W(AW)) mem_if ();

    ov7670_frame_writer #(
        .WIDTH(4), .HEIGHT(2), .ADDR_W(AW), .BASE_ADDR(0), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .vsync(vsync), .newPixel(newPixel),
        .pixelData(pixelData), .mem(mem_if), .overflow(overflow),
        .frameDone(frameDone), .frameCount(frameCount), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_if.memReq && mem_if.memAck) wq.push_back('{mem_if.memAddr, mem_if.memData});
        if (mem_if.memReq) req_cycles++;
        if (frameDone) fd_cycles++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pixel(input logic [15:0] d);
        pixelData = d;
        newPixel  = 1'b1;
        step();
        newPixel  = 1'b0;
        step();
    endtask

    task automatic vsync_pulse();
        vsync = 1'b1;
        repeat (4) step();
        vsync = 1'b0;
        repeat (3) step();
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check({name, "_drain"}, 32'(busy), 32'd0);
    endtask

    // one pixel with memAck high: checks push latency, request timing and the completed write
    task automatic apply_vec(input vec_t v, input string name);
        pixelData = v.data;
        newPixel  = 1'b1;
        step();
        newPixel  = 1'b0;
        @(negedge clk);
        check({name, "_busy"}, 32'(busy), 32'(v.w));
        check({name, "_req0"}, 32'(mem_if.memReq), 32'd0);
        check({name, "_done"}, 32'(frameDone), 32'(v.done));
        @(negedge clk);
        check({name, "_req"}, 32'(mem_if.memReq), 32'(v.w));
        if (v.w) begin
            check({name, "_addr"}, 32'(mem_if.memAddr), 32'(v.addr));
            check({name, "_data"}, 32'(mem_if.memData), 32'(v.data));
        end
        wait_idle(name);
        @(negedge clk);
        #1;
        check({name, "_nwr"}, 32'(wq.size()), 32'(v.w));
        if (v.w && wq.size() > 0) begin
            check({name, "_wa"}, 32'(wq[0].a), 32'(v.addr));
            check({name, "_wd"}, 32'(wq[0].d), 32'(v.data));
        end
        wq.delete();
        step();
    endtask

    initial begin
        n_err = 0;
        n_checks = 0;
        req_cycles = 0;
        fd_cycles = 0;
        t2[0] = '{16'h1234, 1'b1, 17'd0, 1'b0};
        t2[1] = '{16'hABCD, 1'b1, 17'd1, 1'b0};
        t2[2] = '{16'hF00F, 1'b1, 17'd2, 1'b0};
        for (int i = 0; i < 9; i++)
            t4[i] = '{16'h4000 + 16'(i), (i < 8), 17'(i % 8), (i == 7)};

        vsync = 1'b0;
        newPixel = 1'b0;
        pixelData = 16'd0;
        mem_if.memAck = 1'b0;
        reset = 1'b1;
        #1 reset = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req", 32'(mem_if.memReq), 32'd0);
        check("rst_addr", 32'(mem_if.memAddr), 32'd0);
        check("rst_data", 32'(mem_if.memData), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_done", 32'(frameDone), 32'd0);
        check("rst_fcnt", 32'(frameCount), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        step();
        reset = 1'b1;
        step();

        // pixels before any vsync are ignored
        mem_if.memAck = 1'b1;
        req_cycles = 0;
        wq.delete();
        for (int i = 0; i < 5; i++) pixel(16'h1000 + 16'(i));
        repeat (3) step();
        @(negedge clk);
        #1;
        check("idle_req", 32'(req_cycles), 32'd0);
        check("idle_wr", 32'(wq.size()), 32'd0);
        check("idle_fcnt", 32'(frameCount), 32'd0);
        step();

        // first frame, three pixels with memAck held high
        vsync_pulse();
        @(negedge clk);
        check("f1_fcnt", 32'(frameCount), 32'd1);
        step();
        for (int i = 0; i < 3; i++) apply_vec(t2[i], $sformatf("t2_%0d", i));

        // overflow with memAck low: four fit, two are dropped
        vsync_pulse();
        mem_if.memAck = 1'b0;
        for (int i = 0; i < 4; i++) pixel(16'hC000 + 16'(i));
        @(negedge clk);
        check("full_ovf", 32'(overflow), 32'd0);
        check("full_req", 32'(mem_if.memReq), 32'd1);
        check("full_addr", 32'(mem_if.memAddr), 32'd0);
        check("full_fcnt", 32'(frameCount), 32'd2);
        step();
        pixel(16'hC004);
        pixel(16'hC005);
        @(negedge clk);
        check("drop_ovf", 32'(overflow), 32'd1);
        step();
        mem_if.memAck = 1'b1;
        wait_idle("ovf");
        @(negedge clk);
        #1;
        check("ovf_nwr", 32'(wq.size()), 32'd4);
        for (int i = 0; i < 4 && i < wq.size(); i++) begin
            check($sformatf("ovf_wa%0d", i), 32'(wq[i].a), 32'(i));
            check($sformatf("ovf_wd%0d", i), 32'(wq[i].d), 32'h0000C000 + 32'(i));
        end
        wq.delete();
        step();
        apply_vec('{16'hC006, 1'b1, 17'd6, 1'b0}, "ovf_p7");
        check("ovf_sticky", 32'(overflow), 32'd1);

        // full 4x2 frame, then one extra pixel that must be ignored
        vsync_pulse();
        fd_cycles = 0;
        for (int i = 0; i < 9; i++) apply_vec(t4[i], $sformatf("t4_%0d", i));
        @(negedge clk);
        #1;
        check("t4_fd_once", 32'(fd_cycles), 32'd1);
        check("t4_fcnt", 32'(frameCount), 32'd3);
        step();
        vsync_pulse();
        @(negedge clk);
        check("t4_fcnt2", 32'(frameCount), 32'd4);
        step();
        apply_vec('{16'h5A5A, 1'b1, 17'd0, 1'b0}, "t4_restart");

        // vsync edge and pixel edge in the same cycle
        vsync = 1'b1;
        step();
        step();
        pixelData = 16'hBEEF;
        newPixel = 1'b1;
        step();
        newPixel = 1'b0;
        repeat (2) step();
        vsync = 1'b0;
        repeat (3) step();
        @(negedge clk);
        #1;
        check("coin_fcnt", 32'(frameCount), 32'd5);
        check("coin_busy", 32'(busy), 32'd0);
        check("coin_nwr", 32'(wq.size()), 32'd0);
        step();
        apply_vec('{16'h7777, 1'b1, 17'd0, 1'b0}, "coin_next");

        // full FIFO with a completion in the same cycle still accepts the pixel
        mem_if.memAck = 1'b0;
        for (int i = 1; i < 5; i++) pixel(16'h9000 + 16'(i));
        pixelData = 16'h9005;
        newPixel = 1'b1;
        mem_if.memAck = 1'b1;
        step();
        mem_if.memAck = 1'b0;
        newPixel = 1'b0;
        step();
        mem_if.memAck = 1'b1;
        wait_idle("popush");
        @(negedge clk);
        #1;
        check("popush_nwr", 32'(wq.size()), 32'd5);
        for (int i = 0; i < 5 && i < wq.size(); i++) begin
            check($sformatf("popush_wa%0d", i), 32'(wq[i].a), 32'(i + 1));
            check($sformatf("popush_wd%0d", i), 32'(wq[i].d), 32'h00009001 + 32'(i));
        end
        wq.delete();
        step();

        // reset in the middle of a stalled write
        mem_if.memAck = 1'b0;
        pixel(16'h6666);
        @(negedge clk);
        check("mid_req_pre", 32'(mem_if.memReq), 32'd1);
        step();
        reset = 1'b0;
        req_cycles = 0;
        #1;
        check("mid_req", 32'(mem_if.memReq), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_ovf", 32'(overflow), 32'd0);
        check("mid_fcnt", 32'(frameCount), 32'd0);
        check("mid_addr", 32'(mem_if.memAddr), 32'd0);
        step();
        reset = 1'b1;
        mem_if.memAck = 1'b1;
        wq.delete();
        step();
        pixel(16'h1111);
        pixel(16'h2222);
        repeat (3) step();
        @(negedge clk);
        #1;
        check("post_nwr", 32'(wq.size()), 32'd0);
        check("post_req", 32'(req_cycles), 32'd0);
        step();
        vsync_pulse();
        apply_vec('{16'h3333, 1'b1, 17'd0, 1'b0}, "post_first");
        check("post_fcnt", 32'(frameCount), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
